// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - three-way memory bus arbiter with per-tag owner table
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      dcache2mem_command,
  input  logic [XLEN-1:0] dcache2mem_addr,
  input  logic [63:0]     dcache2mem_data,
  input  logic [1:0]      icache2mem_command,
  input  logic [XLEN-1:0] icache2mem_addr,
  input  logic [1:0]      pref2mem_command,
  input  logic [XLEN-1:0] pref2mem_addr,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic [3:0]      mem2dcache_response,
  output logic [3:0]      mem2icache_response,
  output logic [3:0]      mem2pref_response,
  output logic [3:0]      mem2dcache_tag,
  output logic [3:0]      mem2icache_tag,
  output logic [3:0]      mem2pref_tag,
  output logic [63:0]     mem2cache_data,
  output logic            icache_give_way,
  output logic [4:0]      outstanding_count
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_DCACHE = 2'd1,
    OWN_ICACHE = 2'd2,
    OWN_PREF   = 2'd3
  } owner_e;

  owner_e        owner_q [1:15];
  logic [SW-1:0] starve_cnt;

  owner_e grant;
  owner_e ret_owner;
  logic   dcache_req, icache_req, pref_req;
  logic   load_accept, ret_valid;

  assign dcache_req = (dcache2mem_command != BUS_NONE);
  assign icache_req = (icache2mem_command != BUS_NONE);
  assign pref_req   = (pref2mem_command != BUS_NONE);

  // A starved icache overrides the normal dcache-first priority for one grant
  always_comb begin
    grant = OWN_NONE;
    if (icache_req && (starve_cnt == STARVE_MAX)) grant = OWN_ICACHE;
    else if (dcache_req)                           grant = OWN_DCACHE;
    else if (icache_req)                           grant = OWN_ICACHE;
    else if (pref_req)                             grant = OWN_PREF;
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    case (grant)
      OWN_DCACHE: begin
        proc2mem_command = dcache2mem_command;
        proc2mem_addr    = dcache2mem_addr;
        proc2mem_data    = dcache2mem_data;
      end
      OWN_ICACHE: begin
        proc2mem_command = icache2mem_command;
        proc2mem_addr    = icache2mem_addr;
      end
      OWN_PREF: begin
        proc2mem_command = pref2mem_command;
        proc2mem_addr    = pref2mem_addr;
      end
      default: ;
    endcase
  end

  assign load_accept = (grant != OWN_NONE) && (proc2mem_command == BUS_LOAD) &&
                       (mem2proc_response != 4'd0);

  always_comb begin
    ret_owner = OWN_NONE;
    if (mem2proc_tag != 4'd0) ret_owner = owner_q[mem2proc_tag];
  end

  assign ret_valid = (ret_owner != OWN_NONE);

  assign mem2dcache_response = (grant == OWN_DCACHE) ? mem2proc_response : 4'd0;
  assign mem2icache_response = (grant == OWN_ICACHE) ? mem2proc_response : 4'd0;
  assign mem2pref_response   = (grant == OWN_PREF)   ? mem2proc_response : 4'd0;

  assign mem2dcache_tag = (ret_owner == OWN_DCACHE) ? mem2proc_tag : 4'd0;
  assign mem2icache_tag = (ret_owner == OWN_ICACHE) ? mem2proc_tag : 4'd0;
  assign mem2pref_tag   = (ret_owner == OWN_PREF)   ? mem2proc_tag : 4'd0;

  assign mem2cache_data  = mem2proc_data;
  assign icache_give_way = icache_req && (grant != OWN_ICACHE);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i <= 15; i++) owner_q[i] <= OWN_NONE;
      starve_cnt        <= '0;
      outstanding_count <= '0;
    end else begin
      // Clear first so a same-tag accept in this cycle wins the entry
      if (ret_valid)   owner_q[mem2proc_tag]      <= OWN_NONE;
      if (load_accept) owner_q[mem2proc_response] <= grant;

      if (icache_req && (grant != OWN_ICACHE)) begin
        if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end

      case ({load_accept, ret_valid})
        2'b10:   outstanding_count <= outstanding_count + 5'd1;
        2'b01:   outstanding_count <= outstanding_count - 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  localparam int XLEN = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      dcache2mem_command, icache2mem_command, pref2mem_command;
  logic [XLEN-1:0] dcache2mem_addr, icache2mem_addr, pref2mem_addr;
  logic [63:0]     dcache2mem_data, mem2proc_data;
  logic [3:0]      mem2proc_response, mem2proc_tag;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data, mem2cache_data;
  logic [3:0]      mem2dcache_response, mem2icache_response, mem2pref_response;
  logic [3:0]      mem2dcache_tag, mem2icache_tag, mem2pref_tag;
  logic            icache_give_way;
  logic [4:0]      outstanding_count;

  typedef struct {
    logic [3:0] tag;
    logic [1:0] owner;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(4), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .dcache2mem_command(dcache2mem_command), .dcache2mem_addr(dcache2mem_addr),
    .dcache2mem_data(dcache2mem_data),
    .icache2mem_command(icache2mem_command), .icache2mem_addr(icache2mem_addr),
    .pref2mem_command(pref2mem_command), .pref2mem_addr(pref2mem_addr),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem2dcache_response(mem2dcache_response), .mem2icache_response(mem2icache_response),
    .mem2pref_response(mem2pref_response),
    .mem2dcache_tag(mem2dcache_tag), .mem2icache_tag(mem2icache_tag),
    .mem2pref_tag(mem2pref_tag),
    .mem2cache_data(mem2cache_data), .icache_give_way(icache_give_way),
    .outstanding_count(outstanding_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    dcache2mem_command = 2'd0; dcache2mem_addr = '0; dcache2mem_data = '0;
    icache2mem_command = 2'd0; icache2mem_addr = '0;
    pref2mem_command   = 2'd0; pref2mem_addr   = '0;
    mem2proc_response  = 4'd0; mem2proc_tag    = 4'd0; mem2proc_data = '0;
  endtask

  // Expected {dcache, icache, pref} routed tags for a scoreboard entry
  function automatic logic [11:0] route_model(sb_t e);
    case (e.owner)
      2'd1:    return {e.tag, 4'd0, 4'd0};
      2'd2:    return {4'd0, e.tag, 4'd0};
      2'd3:    return {4'd0, 4'd0, e.tag};
      default: return 12'd0;
    endcase
  endfunction

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    settle();
    total++;
    if (proc2mem_command !== 2'd0) begin
      bad++; $display("FAIL reset_cmd got=%0d want=0", proc2mem_command);
    end
    total++;
    if (outstanding_count !== 5'd0) begin
      bad++; $display("FAIL reset_count got=%0d want=0", outstanding_count);
    end
    total++;
    if ({mem2dcache_tag, mem2icache_tag, mem2pref_tag, mem2dcache_response,
         mem2icache_response, mem2pref_response, icache_give_way} !== 25'd0) begin
      bad++; $display("FAIL reset_routes got tags=%h%h%h resp=%h%h%h gw=%b want=0",
        mem2dcache_tag, mem2icache_tag, mem2pref_tag, mem2dcache_response,
        mem2icache_response, mem2pref_response, icache_give_way);
    end
    tick();
  endtask

  task automatic test_priority();
    sb_t e;
    dcache2mem_command = 2'd1; dcache2mem_addr = 32'h100;
    icache2mem_command = 2'd1; icache2mem_addr = 32'h200;
    pref2mem_command   = 2'd1; pref2mem_addr   = 32'h208;
    mem2proc_response  = 4'd3;
    sb.push_back('{tag: 4'd3, owner: 2'd1});
    settle();
    total++;
    if (proc2mem_addr !== 32'h100 || proc2mem_command !== 2'd1) begin
      bad++; $display("FAIL prio_bus got addr=%h cmd=%0d want addr=100 cmd=1",
        proc2mem_addr, proc2mem_command);
    end
    total++;
    if ({mem2dcache_response, mem2icache_response, mem2pref_response, icache_give_way}
        !== {4'd3, 4'd0, 4'd0, 1'b1}) begin
      bad++; $display("FAIL prio_resp got=%h/%h/%h gw=%b want=3/0/0 gw=1",
        mem2dcache_response, mem2icache_response, mem2pref_response, icache_give_way);
    end
    tick();
    idle();
    mem2proc_tag = 4'd3;
    settle();
    e = sb.pop_front();
    total++;
    if ({mem2dcache_tag, mem2icache_tag, mem2pref_tag} !== route_model(e)) begin
      bad++; $display("FAIL prio_ret got=%h%h%h want=%h",
        mem2dcache_tag, mem2icache_tag, mem2pref_tag, route_model(e));
    end
    tick();
    idle();
    settle();
    total++;
    if (outstanding_count !== 5'd0) begin
      bad++; $display("FAIL prio_count got=%0d want=0", outstanding_count);
    end
  endtask

  task automatic test_starvation();
    sb_t e;
    logic            exp_i;
    logic [XLEN-1:0] exp_addr;
    for (int c = 0; c < 10; c++) begin
      idle();
      dcache2mem_command = 2'd1; dcache2mem_addr = 32'h1000 + 32'(c * 8);
      icache2mem_command = 2'd1; icache2mem_addr = 32'h2000 + 32'(c * 8);
      mem2proc_response  = 4'(c + 1);
      exp_i    = (c == 4) || (c == 9);
      exp_addr = exp_i ? icache2mem_addr : dcache2mem_addr;
      sb.push_back('{tag: 4'(c + 1), owner: exp_i ? 2'd2 : 2'd1});
      settle();
      total++;
      if (proc2mem_addr !== exp_addr || icache_give_way !== !exp_i) begin
        bad++; $display("FAIL starve_grant c=%0d got addr=%h gw=%b want addr=%h gw=%b",
          c, proc2mem_addr, icache_give_way, exp_addr, !exp_i);
      end
      total++;
      if ({mem2dcache_response, mem2icache_response} !==
          (exp_i ? {4'd0, 4'(c + 1)} : {4'(c + 1), 4'd0})) begin
        bad++; $display("FAIL starve_resp c=%0d got d=%0d i=%0d want tag %0d to %s",
          c, mem2dcache_response, mem2icache_response, c + 1, exp_i ? "icache" : "dcache");
      end
      tick();
    end
    idle();
    settle();
    total++;
    if (outstanding_count !== 5'd10) begin
      bad++; $display("FAIL starve_count got=%0d want=10", outstanding_count);
    end
    for (int r = 0; r < 10; r++) begin
      idle();
      mem2proc_tag = sb[0].tag;
      e = sb.pop_front();
      settle();
      total++;
      if ({mem2dcache_tag, mem2icache_tag, mem2pref_tag} !== route_model(e)) begin
        bad++; $display("FAIL starve_ret tag=%0d got=%h%h%h want=%h", e.tag,
          mem2dcache_tag, mem2icache_tag, mem2pref_tag, route_model(e));
      end
      tick();
    end
    idle();
    settle();
    total++;
    if (outstanding_count !== 5'd0) begin
      bad++; $display("FAIL starve_drain got=%0d want=0", outstanding_count);
    end
  endtask

  task automatic test_pref_reject();
    sb_t e;
    idle();
    pref2mem_command = 2'd1; pref2mem_addr = 32'h3000; mem2proc_response = 4'd5;
    sb.push_back('{tag: 4'd5, owner: 2'd3});
    settle();
    total++;
    if (mem2pref_response !== 4'd5 || proc2mem_addr !== 32'h3000) begin
      bad++; $display("FAIL pref_resp got resp=%0d addr=%h want 5/3000",
        mem2pref_response, proc2mem_addr);
    end
    tick();
    mem2proc_response = 4'd0;
    settle();
    total++;
    if (mem2pref_response !== 4'd0) begin
      bad++; $display("FAIL pref_reject_resp got=%0d want=0", mem2pref_response);
    end
    tick();
    idle();
    settle();
    total++;
    if (outstanding_count !== 5'd1) begin
      bad++; $display("FAIL pref_reject_count got=%0d want=1", outstanding_count);
    end
    mem2proc_tag = 4'd5;
    e = sb.pop_front();
    settle();
    total++;
    if ({mem2dcache_tag, mem2icache_tag, mem2pref_tag} !== route_model(e)) begin
      bad++; $display("FAIL pref_ret got=%h%h%h want=%h",
        mem2dcache_tag, mem2icache_tag, mem2pref_tag, route_model(e));
    end
    tick();
    idle();
  endtask

  task automatic test_store_same_tag();
    sb_t e;
    idle();
    dcache2mem_command = 2'd2; dcache2mem_addr = 32'h400;
    dcache2mem_data = 64'hDEAD_BEEF_CAFE_F00D; mem2proc_response = 4'd7;
    settle();
    total++;
    if (proc2mem_command !== 2'd2 || proc2mem_data !== 64'hDEAD_BEEF_CAFE_F00D) begin
      bad++; $display("FAIL store_bus got cmd=%0d data=%h want 2/deadbeefcafef00d",
        proc2mem_command, proc2mem_data);
    end
    tick();
    idle();
    mem2proc_tag = 4'd7; mem2proc_data = 64'h0123_4567_89AB_CDEF;
    settle();
    total++;
    if ({mem2dcache_tag, mem2icache_tag, mem2pref_tag} !== 12'd0 ||
        mem2cache_data !== 64'h0123_4567_89AB_CDEF) begin
      bad++; $display("FAIL store_ret got=%h%h%h data=%h want=000 data=0123456789abcdef",
        mem2dcache_tag, mem2icache_tag, mem2pref_tag, mem2cache_data);
    end
    tick();
    idle();
    pref2mem_command = 2'd1; pref2mem_addr = 32'h500; mem2proc_response = 4'd2;
    sb.push_back('{tag: 4'd2, owner: 2'd3});
    tick();
    idle();
    icache2mem_command = 2'd1; icache2mem_addr = 32'h600;
    mem2proc_response = 4'd2; mem2proc_tag = 4'd2;
    e = sb.pop_front();
    sb.push_back('{tag: 4'd2, owner: 2'd2});
    settle();
    total++;
    if ({mem2dcache_tag, mem2icache_tag, mem2pref_tag} !== route_model(e) ||
        mem2icache_response !== 4'd2) begin
      bad++; $display("FAIL same_tag got=%h%h%h iresp=%0d want=%h iresp=2",
        mem2dcache_tag, mem2icache_tag, mem2pref_tag, mem2icache_response, route_model(e));
    end
    tick();
    idle();
    settle();
    total++;
    if (outstanding_count !== 5'd1) begin
      bad++; $display("FAIL same_tag_count got=%0d want=1", outstanding_count);
    end
    mem2proc_tag = 4'd2;
    e = sb.pop_front();
    settle();
    total++;
    if ({mem2dcache_tag, mem2icache_tag, mem2pref_tag} !== route_model(e)) begin
      bad++; $display("FAIL same_tag_next got=%h%h%h want=%h",
        mem2dcache_tag, mem2icache_tag, mem2pref_tag, route_model(e));
    end
    tick();
    idle();
  endtask

  task automatic test_reset_midflight();
    idle();
    dcache2mem_command = 2'd1; dcache2mem_addr = 32'h700; mem2proc_response = 4'd9;
    sb.push_back('{tag: 4'd9, owner: 2'd1});
    tick();
    idle();
    icache2mem_command = 2'd1; icache2mem_addr = 32'h800; mem2proc_response = 4'd10;
    sb.push_back('{tag: 4'd10, owner: 2'd2});
    tick();
    idle();
    pref2mem_command = 2'd1; pref2mem_addr = 32'h900; mem2proc_response = 4'd11;
    sb.push_back('{tag: 4'd11, owner: 2'd3});
    tick();
    idle();
    settle();
    total++;
    if (outstanding_count !== 5'd3) begin
      bad++; $display("FAIL midflight_count got=%0d want=3", outstanding_count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    settle();
    total++;
    if (outstanding_count !== 5'd0) begin
      bad++; $display("FAIL midflight_reset got=%0d want=0", outstanding_count);
    end
    for (int t = 9; t <= 11; t++) begin
      mem2proc_tag = 4'(t);
      settle();
      total++;
      if ({mem2dcache_tag, mem2icache_tag, mem2pref_tag} !== 12'd0) begin
        bad++; $display("FAIL midflight_drop tag=%0d got=%h%h%h want=000", t,
          mem2dcache_tag, mem2icache_tag, mem2pref_tag);
      end
      tick();
    end
    idle();
    settle();
    total++;
    if (outstanding_count !== 5'd0 || sb.size() !== 0) begin
      bad++; $display("FAIL midflight_end got count=%0d sb=%0d want 0/0",
        outstanding_count, sb.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_priority();
    test_starvation();
    test_pref_reject();
    test_store_same_tag();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
